seq_stream_ctrl: RTL and testbench
==================================

// Module: seq_stream_ctrl
// PURPOSE
//   Sequences a stored data word, one bit per step, into the shared 1010 Mealy
//   sequence detector. Bits go in MSB-first at a programmable bit rate.
//   Counts the detector's hits and records the bit index of the first hit.
//   Sits between the register/button front end and the detector instance.
// PARAMETERS
//   WORD_W  16  bits per run (>=4)
//   DIV_W   8   width of bit-period divider input
//   CNT_W   5   width of saturating match counter
//   POS_W   $clog2(WORD_W)  localparam, width of first-hit index
// PORTS
//   i_clock      in   1       single system clock, rising edge
//   i_reset      in   1       asynchronous, active-low reset
//   i_start      in   1       1-cycle pulse: latch i_word/i_div, begin run
//   i_abort      in   1       level; terminates an active run
//   i_word       in   WORD_W  pattern to stream, bit WORD_W-1 first
//   i_div        in   DIV_W   bit period = i_div+1 clocks
//   i_det_hit    in   1       detector Mealy output, valid while o_det_en=1
//   o_det_bit    out  1       serial bit to detector
//   o_det_en     out  1       detector clock-enable, 1 cycle per bit
//   o_det_clr    out  1       synchronous clear to detector, 1 cycle
//   o_busy       out  1       high in CLEAR and SHIFT
//   o_done       out  1       1-cycle pulse on normal completion
//   o_match_cnt  out  CNT_W   hits this run, saturates at all-ones
//   o_first_vld  out  1       at least one hit this run
//   o_first_pos  out  POS_W   bit index (0 = MSB) of first hit
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; shift reg, divider, counters 0.
//   FSM IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
//   IDLE: on i_start & !i_abort:
//     - latch word and div
//     - zero o_match_cnt, o_first_vld, o_first_pos
//     - go to CLEAR
//   CLEAR: o_det_clr=1 for exactly 1 cycle -> SHIFT.
//   SHIFT: divider counts 0..div. On the cycle it equals div:
//     - o_det_en=1; o_det_bit = shift reg MSB
//     - sample i_det_hit that same cycle
//     - shift left; bit index++; divider -> 0
//   Hit: o_match_cnt++ (hold at 2^CNT_W-1). If !o_first_vld, set o_first_vld
//     and load o_first_pos = current bit index.
//   After bit WORD_W-1 is enabled -> DONE.
//     - DONE: o_done=1 one cycle -> IDLE.
//   Latency with div=0: start at cycle 0, CLEAR at 1, bits at 2..WORD_W+1,
//     done at WORD_W+2. Generally done = 2 + WORD_W*(div+1).
//   o_det_bit is 0 whenever o_det_en=0.
//   i_start while busy or in DONE: ignored. Latched word/div stay unchanged.
//   i_abort in CLEAR/SHIFT:
//     - next state IDLE
//     - o_det_clr=1 on the abort cycle
//     - no o_done; partial results held
//   i_abort with i_start in IDLE: start ignored.
//   Results hold until the next accepted start. Async reset mid-run returns to
//     IDLE immediately with outputs cleared.
// STRUCTURE
//   Package seq_pkg:
//     - state enum encoding (IDLE=0, CLEAR=1, SHIFT=2, DONE=3)
//     - default WORD_W/DIV_W/CNT_W constants
//   Sub-module bit_tick_gen: loadable down-counter that produces the 1-cycle
//     bit tick from div. Reused by other serial blocks.
//   FSM, shift register and result registers live in this module.
// TESTING (bench detector = overlapping 1010 Mealy, gated by o_det_en)
//   1. word=16'hAA00, div=0, start -> o_det_en on cycles 2..17.
//      o_match_cnt=3, o_first_pos=3, o_first_vld=1, o_done on cycle 18.
//   2. word=16'hAA00, div=3 -> o_det_en every 4th cycle.
//      o_done at cycle 66; same results as test 1.
//   3. word=16'h0000 -> o_match_cnt=0, o_first_vld=0, o_done still pulses.
//   4. CNT_W=2, word=16'hAAAA -> 7 hits saturate: o_match_cnt=3, o_first_pos=3.
//   5. Abort after 5 bits -> IDLE next cycle, o_det_clr pulse, no o_done.
//      Busy-time i_start ignored; new start from IDLE runs normally.
//   6. i_reset low mid-SHIFT -> all outputs 0 asynchronously; FSM in IDLE.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and state encoding for the serial stream sequencer.
package seq_pkg;

  localparam int unsigned WordWDef = 16;
  localparam int unsigned DivWDef  = 8;
  localparam int unsigned CntWDef  = 5;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t StIdle  = 2'd0;
  localparam seq_state_t StClear = 2'd1;
  localparam seq_state_t StShift = 2'd2;
  localparam seq_state_t StDone  = 2'd3;

endpackage

// File: rtl/bit_tick_gen.sv
// Loadable down-counter emitting a 1-cycle tick every div_i+1 enabled cycles.
module bit_tick_gen #(
  parameter int unsigned DivW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [DivW-1:0] div_i,
  output logic            tick_o
);

  logic [DivW-1:0] cnt_q, cnt_d;

  // Tick when the count hits zero, then reload the period.
  always_comb begin
    tick_o = en_i && (cnt_q == '0);
    cnt_d  = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = tick_o ? div_i : cnt_q - DivW'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_stream_ctrl.sv
// Streams a latched word MSB-first into a 1010 detector and collects its hits.
module seq_stream_ctrl
  import seq_pkg::*;
#(
  parameter  int unsigned WORD_W = WordWDef,
  parameter  int unsigned DIV_W  = DivWDef,
  parameter  int unsigned CNT_W  = CntWDef,
  localparam int unsigned POS_W  = $clog2(WORD_W)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [WORD_W-1:0] i_word,
  input  logic [DIV_W-1:0]  i_div,
  input  logic              i_det_hit,
  output logic              o_det_bit,
  output logic              o_det_en,
  output logic              o_det_clr,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_match_cnt,
  output logic              o_first_vld,
  output logic [POS_W-1:0]  o_first_pos
);

  seq_state_t        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [POS_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fvld_q, fvld_d;
  logic [POS_W-1:0]  fpos_q, fpos_d;

  logic running;
  logic tick;

  assign running = (state_q == StClear) || (state_q == StShift);

  // An abort cycle never emits a bit, so the detector sees no partial step.
  bit_tick_gen #(
    .DivW (DIV_W)
  ) u_tick (
    .clk_i  (i_clock),
    .rst_ni (i_reset),
    .load_i (state_q == StClear),
    .en_i   ((state_q == StShift) && !i_abort),
    .div_i  (div_q),
    .tick_o (tick)
  );

  // Detector-facing and status outputs.
  always_comb begin
    o_det_en    = tick;
    o_det_bit   = tick & word_q[WORD_W-1];
    o_det_clr   = (state_q == StClear) || (running && i_abort);
    o_busy      = running;
    o_done      = (state_q == StDone);
    o_match_cnt = cnt_q;
    o_first_vld = fvld_q;
    o_first_pos = fpos_q;
  end

  // Sequencing and result accumulation.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    div_d   = div_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fvld_d  = fvld_q;
    fpos_d  = fpos_q;
    case (state_q)
      StIdle: begin
        if (i_start && !i_abort) begin
          word_d  = i_word;
          div_d   = i_div;
          idx_d   = '0;
          cnt_d   = '0;
          fvld_d  = 1'b0;
          fpos_d  = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        state_d = i_abort ? StIdle : StShift;
      end
      StShift: begin
        if (i_abort) begin
          state_d = StIdle;
        end else if (tick) begin
          word_d = word_q << 1;
          idx_d  = idx_q + POS_W'(1);
          if (i_det_hit) begin
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (!fvld_q) begin
              fvld_d = 1'b1;
              fpos_d = idx_q;
            end
          end
          if (idx_q == POS_W'(WORD_W - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      word_q  <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fvld_q  <= 1'b0;
      fpos_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fvld_q  <= fvld_d;
      fpos_q  <= fpos_d;
    end
  end

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Randomized self-checking bench for seq_stream_ctrl with a 1010 detector model.
module tb_seq_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] word;
  logic [7:0]  div;

  logic       bit0, en0, clr0, busy0, done0, fvld0, hit0;
  logic [4:0] cnt0;
  logic [3:0] fpos0;
  logic       bit1, en1, clr1, busy1, done1, fvld1, hit1;
  logic [1:0] cnt1;
  logic [3:0] fpos1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_stream_ctrl u_dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
    .i_word(word), .i_div(div), .i_det_hit(hit0),
    .o_det_bit(bit0), .o_det_en(en0), .o_det_clr(clr0), .o_busy(busy0),
    .o_done(done0), .o_match_cnt(cnt0), .o_first_vld(fvld0), .o_first_pos(fpos0)
  );

  seq_stream_ctrl #(.CNT_W(2)) u_dut_sat (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort),
    .i_word(word), .i_div(div), .i_det_hit(hit1),
    .o_det_bit(bit1), .o_det_en(en1), .o_det_clr(clr1), .o_busy(busy1),
    .o_done(done1), .o_match_cnt(cnt1), .o_first_vld(fvld1), .o_first_pos(fpos1)
  );

  // Overlapping 1010 Mealy detectors, one per DUT.
  logic [2:0] hist0, hist1;
  assign hit0 = en0 && ({hist0, bit0} == 4'b1010);
  assign hit1 = en1 && ({hist1, bit1} == 4'b1010);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0 <= '0;
      hist1 <= '0;
    end else begin
      if (clr0) hist0 <= '0;
      else if (en0) hist0 <= {hist0[1:0], bit0};
      if (clr1) hist1 <= '0;
      else if (en1) hist1 <= {hist1[1:0], bit1};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hits of a 1010 search over the first nb bits of w, MSB first.
  function automatic void ref_hits(input logic [15:0] w, input int nb,
                                   output int hits, output int first);
    hits  = 0;
    first = 0;
    for (int i = 3; i < nb; i++) begin
      if (w[18-i] && !w[17-i] && w[16-i] && !w[15-i]) begin
        if (hits == 0) first = i;
        hits++;
      end
    end
  endfunction

  // One run; abort_k >= 0 aborts once abort_k bits have gone out.
  task automatic run(input logic [15:0] w, input int dv, input int abort_k, input bit noise);
    int  done_cyc, cyc, ens, abort_cyc, hits, first, nb;
    bit  aborted, fin;
    bit  e_en, e_clr, e_busy, e_done;
    done_cyc  = 2 + 16 * (dv + 1);
    ens       = 0;
    aborted   = 0;
    abort_cyc = -1;
    fin       = 0;
    @(posedge clk); #1;
    word = w; div = 8'(dv); start = 1'b1; abort = 1'b0;
    cyc = 0;
    while (!fin && cyc < done_cyc + 4) begin
      @(posedge clk); #1;
      cyc++;
      abort = 1'b0;
      start = 1'b0;
      if (noise && !aborted && cyc < done_cyc) begin
        start = 1'($urandom_range(0, 1));
        word  = 16'($urandom);
        div   = 8'($urandom);
      end
      if (abort_k >= 0 && !aborted && ens == abort_k) begin
        abort = 1'b1;
        aborted = 1;
        abort_cyc = cyc;
      end
      @(negedge clk);
      if (aborted && cyc == abort_cyc) begin
        e_en = 0; e_clr = 1; e_busy = 1; e_done = 0;
      end else if (aborted) begin
        e_en = 0; e_clr = 0; e_busy = 0; e_done = 0;
        fin = 1;
      end else begin
        e_clr  = (cyc == 1);
        e_busy = (cyc < done_cyc);
        e_en   = (cyc >= 2) && (cyc < done_cyc) && ((cyc - 2) % (dv + 1) == dv);
        e_done = (cyc == done_cyc);
        if (cyc == done_cyc) fin = 1;
      end
      check_eq("det_en", en0, e_en);
      check_eq("det_clr", clr0, e_clr);
      check_eq("busy", busy0, e_busy);
      check_eq("done", done0, e_done);
      check_eq("det_bit", bit0, e_en ? w[15-ens] : 1'b0);
      if (e_en) ens++;
    end
    check_eq("run_finished", fin, 1'b1);
    start = 1'b0;
    abort = 1'b0;
    nb = aborted ? abort_k : 16;
    ref_hits(w, nb, hits, first);
    check_eq("match_cnt", cnt0, hits);
    check_eq("first_vld", fvld0, hits > 0);
    check_eq("first_pos", fpos0, first);
    check_eq("sat_cnt", cnt1, hits > 3 ? 3 : hits);
    check_eq("sat_first_pos", fpos1, first);
    // Results must survive idle cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("hold_cnt", cnt0, hits);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    word  = '0;
    div   = '0;
    #23;
    check_eq("reset_outs", {bit0, en0, clr0, busy0, done0, cnt0, fvld0, fpos0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", {bit0, en0, clr0, busy0, done0, cnt0, fvld0, fpos0}, 0);

    run(16'hAA00, 0, -1, 0);
    run(16'hAA00, 3, -1, 1);
    run(16'h0000, 0, -1, 0);
    run(16'hAAAA, 1, -1, 1);
    run(16'hAAAA, 0, 5, 1);
    run(16'hAA00, 2, 0, 0);

    // Start together with abort in IDLE is dropped.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; word = 16'hAAAA; div = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("start_abort_busy", busy0, 1'b0);
    check_eq("start_abort_clr", clr0, 1'b0);

    // Asynchronous reset in the middle of SHIFT.
    @(posedge clk); #1;
    start = 1'b1; word = 16'hAA00; div = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs", {bit0, en0, clr0, busy0, done0, cnt0, fvld0, fpos0}, 0);
    check_eq("async_rst_sat", {busy1, cnt1, fvld1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_idle", busy0, 1'b0);
    run(16'hAA00, 0, -1, 0);

    for (int n = 0; n < 20; n++) begin
      run(16'($urandom), $urandom_range(0, 4),
          ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
